// File: rtl/aes192_seq_pkg.sv
// aes192_seq_pkg: constants, types and AES round primitives shared by the AES-192 sequencer.
// Inverse primitives exist only when AES192_SEQ_DECRYPT_EN is defined.
package aes192_seq_pkg;
    localparam int NUM_ROUNDS = 12;
    localparam int NUM_RK = 13;
    localparam int NK = 6;
    localparam int NUM_WORDS = 4 * NUM_RK;
    localparam logic [7:0] RCON [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    typedef enum logic [2:0] {NOKEY, EXPAND, READY, RUN, HOLD} seq_state_t;
    typedef logic [127:0] round_key_t;
    typedef logic [31:0] key_word_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = ginv(a);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic key_word_t sub_word(input key_word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(15 - (4*c + r)) +: 8] = s[8*(15 - (4*((c + r) % 4) + r)) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[32*c +: 32] = mix_col(s[32*c +: 32]);
        return o;
    endfunction

`ifdef AES192_SEQ_DECRYPT_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(15 - (4*c + r)) +: 8] = s[8*(15 - (4*((c - r + 4) % 4) + r)) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
        return o;
    endfunction
`endif
endpackage

// File: rtl/aes192_key_store.sv
// aes192_key_store: 52-word AES-192 round-key store, expanded one GenerateKey6 step per cycle.
// done strobes during the final step; rk is a combinational read of RK[index].
module aes192_key_store
    import aes192_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [191:0]     key,
    input  logic [3:0]       index,
    output logic             done,
    output round_key_t       rk
);
    key_word_t w [NUM_WORDS];
    key_word_t nw [NK];
    key_word_t prev_last;
    logic [3:0] step;
    logic busy;
    logic [5:0] base, rb;

    assign done = busy && step == 4'd8;
    assign base = 6'(step) * 6'd6 - 6'd6;
    assign prev_last = w[base + 6'd5];
    assign rb = {index, 2'b00};
    assign rk = {w[rb], w[rb + 6'd1], w[rb + 6'd2], w[rb + 6'd3]};

    always_comb begin
        nw[0] = w[base] ^ sub_word({prev_last[23:0], prev_last[31:24]}) ^ {RCON[step[2:0] - 3'd1], 24'h0};
        for (int k = 1; k < NK; k++) nw[k] = w[base + 6'(k)] ^ nw[k - 1];
    end

    // word array is intentionally not reset; it is meaningless until an expansion completes
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            step <= 4'd0;
        end else if (load) begin
            for (int k = 0; k < NK; k++) w[k] <= key[191 - 32*k -: 32];
            busy <= 1'b1;
            step <= 4'd1;
        end else if (busy) begin
            for (int j = NK; j < NUM_WORDS; j++)
                if (j / NK == int'(step)) w[j] <= nw[j % NK];
            busy <= !done;
            step <= done ? 4'd0 : step + 4'd1;
        end
    end
endmodule

// File: rtl/aes192_round_sequencer.sv
// aes192_round_sequencer: iterative AES-192 engine, one round per clock behind valid/ready handshakes.
// Define AES192_SEQ_DECRYPT_EN to compile in the inverse datapath and honour Decrypt.
module aes192_round_sequencer
    import aes192_seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         KeyLoad,
    input  logic [191:0] Key,
    output logic         KeyReady,
    input  logic         InValid,
    output logic         InReady,
    input  logic         Decrypt,
    input  logic [127:0] DataIn,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [127:0] DataOut
);
    seq_state_t state;
    logic [3:0] r, rk_index;
    logic dir, dec_in, accept_key, ks_done, last;
    round_key_t rk;
    logic [127:0] st, enc_sr, enc_out, round_out;

    assign InReady = state == READY && !KeyLoad;
    assign accept_key = KeyLoad && (state == NOKEY || state == READY);
    assign last = r == 4'(NUM_ROUNDS);
    assign rk_index = state == RUN ? (dir ? 4'(NUM_ROUNDS) - r : r) : (dec_in ? 4'(NUM_ROUNDS) : 4'd0);
    assign enc_sr = shift_rows(sub_bytes(st));
    assign enc_out = (last ? enc_sr : mix_columns(enc_sr)) ^ rk;

`ifdef AES192_SEQ_DECRYPT_EN
    logic [127:0] dec_ark, dec_out;
    assign dec_in = Decrypt;
    assign dec_ark = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    assign dec_out = last ? dec_ark : inv_mix_columns(dec_ark);
    assign round_out = dir ? dec_out : enc_out;
`else
    logic unused_decrypt;
    assign unused_decrypt = Decrypt;
    assign dec_in = 1'b0;
    assign round_out = enc_out;
`endif

    aes192_key_store u_key_store (
        .clk   (clk),
        .reset (reset),
        .load  (accept_key),
        .key   (Key),
        .index (rk_index),
        .done  (ks_done),
        .rk    (rk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NOKEY;
            KeyReady <= 1'b0;
            OutValid <= 1'b0;
            DataOut <= '0;
            r <= 4'd0;
            dir <= 1'b0;
        end else begin
            case (state)
                NOKEY: if (KeyLoad) state <= EXPAND;
                EXPAND: if (ks_done) begin
                    state <= READY;
                    KeyReady <= 1'b1;
                end
                READY: if (KeyLoad) begin
                    state <= EXPAND;
                    KeyReady <= 1'b0;
                end else if (InValid) begin
                    dir <= dec_in;
                    st <= DataIn ^ rk;
                    r <= 4'd1;
                    state <= RUN;
                end
                RUN: if (r == 4'd0 || r > 4'(NUM_ROUNDS)) begin
                    state <= READY;
                end else begin
                    st <= round_out;
                    r <= last ? r : r + 4'd1;
                    if (last) begin
                        DataOut <= round_out;
                        OutValid <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: if (OutReady) begin
                    OutValid <= 1'b0;
                    state <= READY;
                end
                default: state <= NOKEY;
            endcase
        end
    end
endmodule

// File: tb/tb_aes192_round_sequencer.sv
// tb_aes192_round_sequencer: vector table plus randomized blocks against a byte-level AES-192 model.
// Decrypt expectations follow AES192_SEQ_DECRYPT_EN.
module tb_aes192_round_sequencer;
    logic clk = 1'b0;
    logic reset, KeyLoad, KeyReady, InValid, InReady, Decrypt, OutValid, OutReady;
    logic [191:0] Key;
    logic [127:0] DataIn, DataOut;
    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];
    logic [7:0] isb [256];

`ifdef AES192_SEQ_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef struct {
        logic [191:0] key;
        logic [127:0] din;
        logic         dec;
        logic [127:0] want;
    } vec_t;
    vec_t vt [4];

    always #5 clk = ~clk;

    aes192_round_sequencer dut (
        .clk(clk), .reset(reset), .KeyLoad(KeyLoad), .Key(Key), .KeyReady(KeyReady),
        .InValid(InValid), .InReady(InReady), .Decrypt(Decrypt), .DataIn(DataIn),
        .OutValid(OutValid), .OutReady(OutReady), .DataOut(DataOut)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input int k);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int b = 0; b < 4; b++) begin
            if (k[b]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box built by walking generator 3 and its inverse, independent of any field-inverse formula
    task automatic gen_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [31:0] mixw(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3, input logic inv);
        logic [7:0] a [4];
        logic [31:0] res;
        int m0, m1, m2, m3;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        if (inv) begin m0 = 14; m1 = 11; m2 = 13; m3 = 9; end
        else begin m0 = 2; m1 = 3; m2 = 1; m3 = 1; end
        for (int r = 0; r < 4; r++)
            res[31 - 8*r -: 8] = gm(a[r], m0) ^ gm(a[(r + 1) % 4], m1) ^ gm(a[(r + 2) % 4], m2) ^ gm(a[(r + 3) % 4], m3);
        return res;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [191:0] key, input logic [127:0] blk, input logic dec);
        logic [31:0] w [52];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [31:0] tmp;
        logic [7:0] rc;
        logic [127:0] res;
        int rnd;
        for (int i = 0; i < 6; i++) w[i] = key[191 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            tmp = w[i - 1];
            if (i % 6 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 6] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = blk[127 - 8*i -: 8];
        for (int k = 0; k < 13; k++) begin
            rnd = dec ? 12 - k : k;
            if (k > 0) begin
                t = s;
                for (int i = 0; i < 16; i++)
                    s[i] = dec ? isb[t[(i + 16 - 4*(i % 4)) % 16]] : sb[t[(i + 4*(i % 4)) % 16]];
                if (!dec && k < 12)
                    for (int c = 0; c < 4; c++)
                        {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = mixw(s[4*c], s[4*c+1], s[4*c+2], s[4*c+3], 1'b0);
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i % 4) -: 8];
            if (dec && k > 0 && k < 12)
                for (int c = 0; c < 4; c++)
                    {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = mixw(s[4*c], s[4*c+1], s[4*c+2], s[4*c+3], 1'b1);
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic wait_key(input string nm);
        int n, bad;
        n = 0;
        bad = 0;
        while (!KeyReady && n < 20) begin
            if (InReady || OutValid) bad++;
            @(negedge clk);
            n++;
        end
        chk_i({nm, "_key_latency"}, n, 8);
        chk_i({nm, "_busy_outputs_low"}, bad, 0);
    endtask

    task automatic load_key(input logic [191:0] k, input string nm);
        KeyLoad = 1'b1;
        Key = k;
        @(negedge clk);
        KeyLoad = 1'b0;
        wait_key(nm);
    endtask

    task automatic run_block(input logic [127:0] din, input logic dec, input logic [127:0] want,
                             input string nm, input int kl_at, input logic [191:0] kl_key);
        int n;
        n = 0;
        while (!InReady && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk_i({nm, "_inready"}, int'(InReady), 1);
        InValid = 1'b1;
        DataIn = din;
        Decrypt = dec;
        @(negedge clk);
        InValid = 1'b0;
        Decrypt = 1'b0;
        DataIn = '0;
        n = 0;
        while (!OutValid && n < 40) begin
            KeyLoad = n == kl_at;
            Key = kl_key;
            @(negedge clk);
            n++;
        end
        KeyLoad = 1'b0;
        chk_i({nm, "_latency"}, n, 12);
        chk({nm, "_data"}, DataOut, want);
    endtask

    task automatic finish_block(input string nm);
        @(negedge clk);
        chk_i({nm, "_outvalid_drop"}, int'(OutValid), 0);
        chk_i({nm, "_inready_back"}, int'(InReady), 1);
    endtask

    initial begin
        logic [191:0] kf, cur_key, k2;
        logic [127:0] pf, cf, b, want;
        logic d;
        int bad;
        gen_sbox();
        reset = 1'b1; KeyLoad = 1'b0; Key = '0; InValid = 1'b0;
        Decrypt = 1'b0; DataIn = '0; OutReady = 1'b1;
        repeat (3) @(negedge clk);
        chk_i("reset_keyready", int'(KeyReady), 0);
        chk_i("reset_inready", int'(InReady), 0);
        chk_i("reset_outvalid", int'(OutValid), 0);
        chk("reset_dataout", DataOut, '0);
        reset = 1'b0;
        @(negedge clk);
        chk_i("nokey_inready", int'(InReady), 0);

        kf = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        pf = 128'h00112233445566778899aabbccddeeff;
        cf = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        cur_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        vt[0] = '{kf, pf, 1'b0, cf};
        vt[1] = '{kf, cf, 1'b1, DEC_EN ? pf : aes_ref(kf, cf, 1'b0)};
        b = {$urandom, $urandom, $urandom, $urandom};
        vt[2] = '{cur_key, b, 1'b0, aes_ref(cur_key, b, 1'b0)};
        b = {$urandom, $urandom, $urandom, $urandom};
        vt[3] = '{cur_key, b, 1'b1, aes_ref(cur_key, b, DEC_EN)};
        for (int i = 0; i < 4; i++) begin
            if (i == 0 || vt[i].key != vt[i-1].key) load_key(vt[i].key, $sformatf("vec%0d", i));
            run_block(vt[i].din, vt[i].dec, vt[i].want, $sformatf("vec%0d", i), -1, '0);
            finish_block($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            cur_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            load_key(cur_key, $sformatf("rnd%0d", i));
            b = {$urandom, $urandom, $urandom, $urandom};
            d = 1'($urandom_range(0, 1));
            run_block(b, d, aes_ref(cur_key, b, d && DEC_EN), $sformatf("rnd%0d", i), -1, '0);
            finish_block($sformatf("rnd%0d", i));
        end

        OutReady = 1'b0;
        b = {$urandom, $urandom, $urandom, $urandom};
        want = aes_ref(cur_key, b, 1'b0);
        run_block(b, 1'b0, want, "bp", -1, '0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (DataOut !== want || !OutValid || InReady) bad++;
        end
        chk_i("bp_hold_stable", bad, 0);
        OutReady = 1'b1;
        finish_block("bp");

        k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        run_block(b, 1'b0, aes_ref(cur_key, b, 1'b0), "klrun", 3, k2);
        chk_i("klrun_keyready", int'(KeyReady), 1);
        finish_block("klrun");
        b = {$urandom, $urandom, $urandom, $urandom};
        run_block(b, 1'b0, aes_ref(cur_key, b, 1'b0), "klrun_after", -1, '0);
        finish_block("klrun_after");

        KeyLoad = 1'b1;
        Key = k2;
        InValid = 1'b1;
        DataIn = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk_i("kl_inv_inready", int'(InReady), 0);
        @(negedge clk);
        KeyLoad = 1'b0;
        InValid = 1'b0;
        chk_i("kl_inv_keyready", int'(KeyReady), 0);
        wait_key("kl_inv");
        cur_key = k2;
        b = {$urandom, $urandom, $urandom, $urandom};
        run_block(b, 1'b0, aes_ref(cur_key, b, 1'b0), "kl_inv_new", -1, '0);
        finish_block("kl_inv_new");

        InValid = 1'b1;
        DataIn = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        InValid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_i("rst_mid_outvalid", int'(OutValid), 0);
        chk_i("rst_mid_keyready", int'(KeyReady), 0);
        chk_i("rst_mid_inready", int'(InReady), 0);
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (OutValid || InReady || KeyReady) bad++;
        end
        chk_i("rst_mid_quiet", bad, 0);
        load_key(kf, "reload");
        run_block(pf, 1'b0, cf, "reload", -1, '0);
        finish_block("reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes192_round_sequencer.md
# aes192_round_sequencer

Iterative, multi-cycle AES-192 engine controller that replaces the fully unrolled 12-round combinational cipher with one shared round datapath sequenced by an FSM. It expands a 192-bit key once into 13 stored round keys. It then processes 128-bit blocks at one round per clock, in either direction, using the codebase's existing round primitives (SubBytes/FullSubBytes, ShiftRows, MixColumns, AddRoundKey and their inverses). It sits between a block-level valid/ready producer and consumer.

## Interface
Parameters: none. All constants come from the package.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- KeyLoad  in  1  one-cycle request to load and expand Key
- Key  in  192  cipher key, sampled on accepted KeyLoad
- KeyReady  out  1  round-key store valid
- InValid  in  1  block offered
- InReady  out  1  block accepted when InValid && InReady
- Decrypt  in  1  direction, sampled with DataIn (1 = decrypt)
- DataIn  in  128  input block
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts result
- DataOut  out  128  result block

## Operation
- FSM states: NOKEY, EXPAND, READY, RUN, HOLD. Reset enters NOKEY.
- KeyLoad is accepted only in NOKEY or READY; in RUN, HOLD and EXPAND it is ignored. On acceptance:
  - store RK words w0..w5 = Key;
  - go to EXPAND and clear KeyReady.
- EXPAND performs one GenerateKey6 step per cycle, steps 1..8, with Rcon 01,02,04,08,10,20,40,80.
  - Each step appends 6 words; step 8 appends only w48..w51.
  - Round key RK[i] = w4i..w4i+3, MSB-first, for i = 0..12.
- After step 8 the FSM moves to READY and sets KeyReady.
- InReady = (state == READY) && !KeyLoad. A simultaneous KeyLoad wins and the block is not accepted.
- On accept, the FSM latches Decrypt into a direction flag and loads the state register:
  - encrypt: DataIn ^ RK[0];
  - decrypt: DataIn ^ RK[12].
  - Round counter r = 1; go to RUN.
- RUN, one round per cycle, r = 1..12:
  - encrypt: Sub → Shift → Mix (skipped when r = 12) → ^RK[r];
  - decrypt: InvShift → InvSub → ^RK[12−r] → InvMix (skipped when r = 12).
- At r = 12 the result goes to DataOut, OutValid is set, and the FSM enters HOLD.
- HOLD: DataOut and OutValid stay stable until OutValid && OutReady, then the FSM returns to READY. There is no bypass, so a new block can be accepted the cycle after the handshake at the earliest.
- The round counter is 4 bits and counts 1..12. It never wraps. Values 0, 13, 14 and 15 are unreachable and force a return to READY.

## Timing
- Reset values: KeyReady = 0, InReady = 0, OutValid = 0, DataOut = 0, round counter = 0. The RK store is not cleared but is invalid.
- Key expansion: KeyLoad accepted at edge E0; KeyReady rises after edge E8 (8 cycles).
- Block latency: accept at edge A0; OutValid rises after edge A12 (12 cycles).
- Throughput: 14 cycles per block with OutReady held high (accept, 12 rounds, 1 HOLD cycle).
- A reset asserted in any state takes effect at the next edge and returns to NOKEY. An in-flight block is discarded and the key must be reloaded.
- OutReady while OutValid = 0 has no effect.

## Configuration
- AES192_SEQ_DECRYPT_EN:
  - Defined: inverse datapath and Decrypt support are compiled in.
  - Undefined: the inverse round logic is absent, Decrypt is ignored, and every block is encrypted. Latency is unchanged.

## Structure
- Package aes192_seq_pkg holds:
  - NUM_ROUNDS = 12, NUM_RK = 13, NK = 6;
  - the Rcon byte table for steps 1..8;
  - the FSM state enum;
  - the round_key_t (128-bit) and key_word_t (32-bit) typedefs.
- Sub-module aes192_key_store holds:
  - the 52-word register file and the expansion step counter;
  - ports for load, busy/done, and a combinational read of RK[index].
- The top level contains the FSM, the round counter, the state register and the round datapath instances.

## Test plan
- Reset, then KeyLoad with Key = 000102030405060708090a0b0c0d0e0f1011121314151617 → KeyReady rises exactly 8 cycles later; InReady = 0 until then.
- Encrypt DataIn = 00112233445566778899aabbccddeeff with OutReady = 1 → DataOut = dda97ca4864cdfe06eaf70a0ec0d7191, OutValid 12 cycles after accept.
- With AES192_SEQ_DECRYPT_EN defined, decrypt dda97ca4864cdfe06eaf70a0ec0d7191 → 00112233445566778899aabbccddeeff.
- Backpressure: hold OutReady = 0 for 20 cycles → DataOut stable, OutValid stays 1, InReady = 0. Release → InReady high the next cycle.
- KeyLoad asserted during RUN → ignored; the result still matches the old key. KeyLoad and InValid together in READY → block not accepted, EXPAND entered.
- Reset asserted at round 6 → OutValid = 0, KeyReady = 0 next cycle; no output produced for that block.
